hack_mem_responder: RTL and testbench

Memory-side responder for the Hack `CPU`. It returns the instruction at `PC` (`outROM`) and the data word at `addRAM` (`outRAM`), and it commits CPU writes (`inRAM` when `enM`). Data space is memory-mapped into RAM, screen and keyboard. A byte-stream loader fills instruction ROM after reset and holds the CPU in reset until loading completes. The block sits beside `CPU` in the Hack top level and is the hardware counterpart of the stimulus the CPU bench drives by hand.

---
 rtl/hack_mem_responder.sv | 200 ++++++++++++++++++++
 tb/tb_hack_mem_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : hack_mem_responder
// Description : Memory-side responder for the Hack CPU. It serves
//               instructions from ROM and data from a memory-mapped space
//               (RAM / screen / keyboard). It also commits CPU writes and
//               fills the ROM from a byte-stream loader. The CPU is held in
//               reset until loading completes.
//   clk, rst           : single clock, synchronous active-high reset
//   PC / outROM        : instruction fetch (combinational, 0 while loading)
//   addRAM / inRAM /
//   enM / outRAM       : data access (combinational read, write on edge)
//   cpu_rst            : high while the ROM is being loaded
//   ld_valid / ld_ready /
//   ld_data / ld_last  : loader byte stream (high byte first)
//   reload             : restart loading at ROM address 0 (only in RUN)
//   kbd                : keyboard scan code, mapped read-only at 0x6000
//   scr_rd_addr /
//   scr_rd_data        : registered display read port
// Revision    : 1.0 - initial release
// ============================================================================
module hack_mem_responder #(
    parameter int N      = 16,
    parameter int ROM_AW = 15,
    parameter int RAM_AW = 14,
    parameter int SCR_AW = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      PC,
    input  logic [N-1:0]      addRAM,
    input  logic [N-1:0]      inRAM,
    input  logic              enM,
    output logic [N-1:0]      outROM,
    output logic [N-1:0]      outRAM,
    output logic              cpu_rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    input  logic              reload,
    input  logic [N-1:0]      kbd,
    input  logic [SCR_AW-1:0] scr_rd_addr,
    output logic [N-1:0]      scr_rd_data
);

    localparam logic [1:0] c_LD_HI = 2'd0;
    localparam logic [1:0] c_LD_LO = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;

    localparam logic [ROM_AW-1:0] c_ROM_LAST = '1;
    // The screen occupies the page directly above RAM. The keyboard is the
    // first word of the page after the screen.
    localparam logic [N-1:0] c_SCR_PAGE = N'(2);
    localparam logic [N-1:0] c_KBD_ADDR = N'(3) << SCR_AW;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ROM_AW-1:0] r_ld_addr;
    logic [7:0]        r_hi_byte;
    logic [N-1:0]      r_scr_rd_data;

    logic [N-1:0] r_rom [0:(1<<ROM_AW)-1];
    logic [N-1:0] r_ram [0:(1<<RAM_AW)-1];
    logic [N-1:0] r_scr [0:(1<<SCR_AW)-1];

    logic w_accept;
    logic w_run;
    logic w_is_ram;
    logic w_is_scr;
    logic w_is_kbd;
    logic w_ram_we;
    logic w_scr_we;
    logic w_unused_pc;

    assign w_unused_pc = &{1'b0, PC[N-1:ROM_AW]};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_LD_HI;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_LD_HI: begin
                if (w_accept) begin
                    w_next_state = c_LD_LO;
                end
            end
            c_LD_LO: begin
                if (w_accept) begin
                    // A full ROM ends the load even without ld_last.
                    if (ld_last || (r_ld_addr == c_ROM_LAST)) begin
                        w_next_state = c_RUN;
                    end else begin
                        w_next_state = c_LD_HI;
                    end
                end
            end
            c_RUN: begin
                if (reload) begin
                    w_next_state = c_LD_HI;
                end
            end
            default: w_next_state = c_LD_HI;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_run    = (r_state == c_RUN);
        cpu_rst  = !w_run;
        ld_ready = !w_run && !rst;
    end

    assign w_accept = ld_valid && ld_ready;

    // ------------------------------------------------------------------
    // Loader datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_addr <= '0;
            r_hi_byte <= '0;
        end else begin
            if ((r_state == c_LD_HI) && w_accept) begin
                r_hi_byte <= ld_data;
            end
            // The address saturates at the last word so it never wraps.
            if ((r_state == c_LD_LO) && w_accept && (r_ld_addr != c_ROM_LAST)) begin
                r_ld_addr <= r_ld_addr + 1'b1;
            end
            if (w_run && reload) begin
                r_ld_addr <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == c_LD_LO) && w_accept) begin
            r_rom[r_ld_addr] <= N'({r_hi_byte, ld_data});
        end
    end

    assign outROM = w_run ? r_rom[PC[ROM_AW-1:0]] : '0;

    // ------------------------------------------------------------------
    // Data space decode
    // ------------------------------------------------------------------
    assign w_is_ram = ((addRAM >> RAM_AW) == '0);
    assign w_is_scr = ((addRAM >> SCR_AW) == c_SCR_PAGE);
    assign w_is_kbd = (addRAM == c_KBD_ADDR);
    assign w_ram_we = w_run && enM && w_is_ram;
    assign w_scr_we = w_run && enM && w_is_scr;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[addRAM[RAM_AW-1:0]] <= inRAM;
        end
        if (w_scr_we) begin
            r_scr[addRAM[SCR_AW-1:0]] <= inRAM;
        end
    end

    always_comb begin
        outRAM = '0;
        if (w_is_ram) begin
            outRAM = r_ram[addRAM[RAM_AW-1:0]];
        end else if (w_is_scr) begin
            outRAM = r_scr[addRAM[SCR_AW-1:0]];
        end else if (w_is_kbd) begin
            outRAM = kbd;
        end
    end

    // Display port: a same-edge CPU write is not visible until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scr_rd_data <= '0;
        end else begin
            r_scr_rd_data <= r_scr[scr_rd_addr];
        end
    end

    assign scr_rd_data = r_scr_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_hack_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_mem_responder
// Description : Self-checking bench for hack_mem_responder. The stimulus
//               queues expected outputs from a reference model. A monitor
//               compares them against the DUT on the falling clock edge.
//               A second instance with a 4-word ROM exercises the
//               ROM-full case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_mem_responder;

    localparam int ROMSZ = 32768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enM, ld_valid, ld_last, reload;
    logic [15:0] PC, addRAM, inRAM, kbd;
    logic [7:0]  ld_data;
    logic [12:0] scr_rd_addr;
    wire  [15:0] outROM, outRAM, scr_rd_data;
    wire         cpu_rst, ld_ready;

    hack_mem_responder dut (
        .clk(clk), .rst(rst), .PC(PC), .addRAM(addRAM), .inRAM(inRAM), .enM(enM),
        .outROM(outROM), .outRAM(outRAM), .cpu_rst(cpu_rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .reload(reload), .kbd(kbd), .scr_rd_addr(scr_rd_addr), .scr_rd_data(scr_rd_data)
    );

    // Small instance: ROM_AW = 2
    logic        s_rst, s_ld_valid;
    logic [7:0]  s_ld_data;
    logic [15:0] s_PC;
    wire  [15:0] s_outROM, s_outRAM, s_scr_rd_data;
    wire         s_cpu_rst, s_ld_ready;
    logic [15:0] s_zero16 = 16'h0;
    logic [12:0] s_zero13 = 13'h0;
    logic        s_zero1  = 1'b0;

    hack_mem_responder #(.N(16), .ROM_AW(2), .RAM_AW(14), .SCR_AW(13)) dut_small (
        .clk(clk), .rst(s_rst), .PC(s_PC), .addRAM(s_zero16), .inRAM(s_zero16), .enM(s_zero1),
        .outROM(s_outROM), .outRAM(s_outRAM), .cpu_rst(s_cpu_rst),
        .ld_valid(s_ld_valid), .ld_ready(s_ld_ready), .ld_data(s_ld_data), .ld_last(s_zero1),
        .reload(s_zero1), .kbd(s_zero16), .scr_rd_addr(s_zero13), .scr_rd_data(s_scr_rd_data)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   small_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int due, input int sel, input logic [15:0] exp, input string name);
        exp_t e;
        e.due = due; e.sel = sel; e.exp = exp; e.name = name;
        sbq.push_back(e);
    endtask

    function automatic logic [15:0] pick(input int sel);
        case (sel)
            0:  return outROM;
            1:  return outRAM;
            2:  return scr_rd_data;
            3:  return {15'b0, cpu_rst};
            4:  return {15'b0, ld_ready};
            10: return s_outROM;
            11: return {15'b0, s_cpu_rst};
            12: return {15'b0, s_ld_ready};
            default: return 16'hDEAD;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                logic [15:0] got;
                got = pick(sbq[i].sel);
                n_checks++;
                if (got !== sbq[i].exp) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %h expected %h", sbq[i].name, cyc, got, sbq[i].exp);
                end
                sbq.delete(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: memories plus "which bytes of which word have arrived"
    // ------------------------------------------------------------------
    logic [15:0] rom_m [0:ROMSZ-1];
    bit          rom_k [0:ROMSZ-1];
    logic [15:0] ram_m [0:16383];
    bit          ram_k [0:16383];
    logic [15:0] scr_m [0:8191];
    bit          scr_k [0:8191];
    bit          m_run = 1'b0;
    int          m_bytes = 0;   // bytes of the current word received (0 or 1)
    int          m_word = 0;    // number of words loaded in this load
    logic [7:0]  m_hi;

    // Model read of the data space; returns 0 in known=0 when unpredictable.
    task automatic m_read(input logic [15:0] a, output logic [15:0] d, output bit known);
        int ia;
        ia = int'(a);
        known = 1'b1;
        d = 16'h0;
        if (ia < 16'h4000) begin
            known = ram_k[ia]; d = ram_m[ia];
        end else if (ia < 16'h6000) begin
            known = scr_k[ia - 16'h4000]; d = scr_m[ia - 16'h4000];
        end else if (ia == 16'h6000) begin
            d = kbd;
        end
    endtask

    // One clock cycle with the currently driven inputs.
    task automatic cycle();
        logic [15:0] d;
        bit          k;
        int          pa;
        push(cyc, 4, {15'b0, !m_run && !rst}, "ld_ready");
        push(cyc, 3, {15'b0, !m_run}, "cpu_rst");
        pa = int'(PC[14:0]);
        if (!m_run) push(cyc, 0, 16'h0, "outROM_load");
        else if (rom_k[pa]) push(cyc, 0, rom_m[pa], "outROM");
        m_read(addRAM, d, k);
        if (k) push(cyc, 1, d, "outRAM");
        if (rst) push(cyc + 1, 2, 16'h0, "scr_rd_rst");
        else if (scr_k[int'(scr_rd_addr)]) push(cyc + 1, 2, scr_m[int'(scr_rd_addr)], "scr_rd_data");

        // Effect of the coming edge.
        if (rst) begin
            m_run = 1'b0; m_bytes = 0; m_word = 0;
        end else if (!m_run) begin
            if (ld_valid) begin
                if (m_bytes == 0) begin
                    m_hi = ld_data; m_bytes = 1;
                end else begin
                    rom_m[m_word] = {m_hi, ld_data};
                    rom_k[m_word] = 1'b1;
                    m_bytes = 0;
                    m_word++;
                    if (ld_last || m_word == ROMSZ) m_run = 1'b1;
                end
            end
        end else begin
            if (enM) begin
                if (int'(addRAM) < 16'h4000) begin
                    ram_m[int'(addRAM)] = inRAM; ram_k[int'(addRAM)] = 1'b1;
                end else if (int'(addRAM) < 16'h6000) begin
                    scr_m[int'(addRAM) - 16'h4000] = inRAM; scr_k[int'(addRAM) - 16'h4000] = 1'b1;
                end
            end
            if (reload) begin
                m_run = 1'b0; m_bytes = 0; m_word = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
        for (int g = 0; g < gap; g++) begin
            ld_valid = 1'b0;
            cycle();
        end
        ld_valid = 1'b1; ld_data = b; ld_last = last;
        cycle();
        ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
        addRAM = a; inRAM = d; enM = 1'b1;
        cycle();
        enM = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] w;
        rst = 1'b1; enM = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; reload = 1'b0;
        PC = 16'h0; addRAM = 16'h0; inRAM = 16'h0; kbd = 16'h0; ld_data = 8'h0;
        scr_rd_addr = 13'h0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Reset after a high-byte accept discards the partial word.
        send_byte(8'hAB, 1'b0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        w = 16'($urandom);
        send_byte(w[15:8], 1'b0, 1);
        send_byte(w[7:0], 1'b1, 0);
        PC = 16'h0;
        cycle();

        // Seed RAM[0x20], then reload in RUN.
        cpu_wr(16'h0020, 16'($urandom));
        reload = 1'b1;
        cycle();
        reload = 1'b0;

        // Load with gaps while the CPU tries to write RAM[0x20].
        addRAM = 16'h0020; inRAM = 16'($urandom); enM = 1'b1;
        send_byte(8'h00, 1'b0, int'($urandom_range(0, 2)));
        send_byte(8'h05, 1'b0, int'($urandom_range(0, 2)));
        send_byte(8'hEC, 1'b0, int'($urandom_range(0, 2)));
        send_byte(8'h10, 1'b1, int'($urandom_range(0, 2)));
        enM = 1'b0;
        PC = 16'h0; cycle();
        PC = 16'h1; cycle();

        // Data map.
        cpu_wr(16'h0010, 16'h1234);
        cycle();
        addRAM = 16'h6000; kbd = 16'h0041; cycle();
        cpu_wr(16'h6000, 16'hBEEF);
        cycle();
        addRAM = 16'h7000; cycle();
        cpu_wr(16'h0003, 16'h5A5A);
        scr_rd_addr = 13'd3;
        cpu_wr(16'h4003, 16'hFFFF);
        cycle();
        addRAM = 16'h0003; cycle();
        // Same-cycle screen write and display read: old data next cycle.
        cpu_wr(16'h4003, 16'h0F0F);
        cycle();
        // Same-cycle RAM read/write: old data visible.
        cpu_wr(16'h0010, 16'h4321);
        cycle();

        // Reload together with a write: the write still lands.
        addRAM = 16'h0011; inRAM = 16'hCAFE; enM = 1'b1; reload = 1'b1;
        cycle();
        enM = 1'b0; reload = 1'b0;
        w = 16'($urandom);
        send_byte(w[15:8], 1'b0, 0);
        send_byte(w[7:0], 1'b1, 0);
        addRAM = 16'h0011; PC = 16'h0;
        cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            reload   = ($urandom_range(0, 29) == 0);
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = 8'($urandom);
            ld_last  = ($urandom_range(0, 3) == 0);
            enM      = 1'($urandom_range(0, 1));
            inRAM    = 16'($urandom);
            kbd      = 16'($urandom);
            case ($urandom_range(0, 3))
                0: addRAM = 16'($urandom_range(0, 31));
                1: addRAM = 16'(16'h4000 + $urandom_range(0, 31));
                2: addRAM = 16'h6000;
                default: addRAM = 16'($urandom_range(16'h6001, 16'hFFFF));
            endcase
            scr_rd_addr = 13'($urandom_range(0, 31));
            PC = 16'($urandom_range(0, 7));
            cycle();
        end
        rst = 1'b0; enM = 1'b0; reload = 1'b0; ld_valid = 1'b0;

        while (!small_done) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ------------------------------------------------------------------
    // Small-ROM stimulus: 5 words streamed without ld_last into 4 words.
    // ------------------------------------------------------------------
    initial begin
        s_rst = 1'b1; s_ld_valid = 1'b0; s_ld_data = 8'h0; s_PC = 16'h0;
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            s_ld_valid = 1'b1;
            s_ld_data  = 8'(j);
            push(cyc, 12, {15'b0, j < 8}, "small_ld_ready");
            push(cyc, 11, {15'b0, j < 8}, "small_cpu_rst");
            @(posedge clk);
            #1;
        end
        s_ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_PC = 16'(k);
            push(cyc, 10, {8'(2 * k), 8'(2 * k + 1)}, "small_outROM");
            @(posedge clk);
            #1;
        end
        small_done = 1'b1;
    end

endmodule
`default_nettype wire
